// File: rtl/bbox_pkg.sv
// Shared types and constants for the per-frame bounding-box tracker.
// Holds the coordinate width, the FSM state type and the smoothing average helper.
package bbox_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [0:0] {
    WAIT = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic [COORD_W-1:0] COORD_MAX  = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};

  // Mean of two coordinates; the carry bit keeps the sum exact before the shift.
  function automatic logic [COORD_W-1:0] coord_avg(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W:1];
  endfunction

endpackage

// File: rtl/bbox_axis_acc.sv
// One-axis min/max accumulator for the bounding-box tracker.
// A clear together with an update seeds the new frame with that coordinate.
import bbox_pkg::*;

module bbox_axis_acc (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               upd,
  input  logic [COORD_W-1:0] coord,
  output logic [COORD_W-1:0] min,
  output logic [COORD_W-1:0] max
);

  // Min/max registers; equal coordinates never change the stored extreme.
  always_ff @(posedge clk) begin
    if (rst) begin
      min <= COORD_MAX;
      max <= COORD_ZERO;
    end else if (clear) begin
      min <= upd ? coord : COORD_MAX;
      max <= upd ? coord : COORD_ZERO;
    end else if (upd) begin
      if (coord < min) begin
        min <= coord;
      end
      if (coord > max) begin
        max <= coord;
      end
    end
  end

endmodule

// File: rtl/target_bbox_tracker.sv
// Per-frame bounding box of edge pixels inside a region of interest, published at each vsync.
// Optional macro BBOX_SMOOTH_EN averages consecutive valid boxes instead of loading them directly.
import bbox_pkg::*;

module target_bbox_tracker #(
  parameter int CNT_W   = 20,
  parameter int MIN_PIX = 64,
  parameter int ROI_X0  = 0,
  parameter int ROI_X1  = 639,
  parameter int ROI_Y0  = 64,
  parameter int ROI_Y1  = 479,
  parameter bit VS_POL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               pix_valid,
  input  logic               pix_bit,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic               bbox_valid,
  output logic [CNT_W-1:0]   pix_count,
  output logic               frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIX);

  logic               vsync_d_r;
  logic               boundary_s;
  logic               qual_s;
  logic               publish_s;
  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [COORD_W-1:0] acc_x_min_s, acc_x_max_s, acc_y_min_s, acc_y_max_s;
  logic [COORD_W-1:0] nxt_x_min_s, nxt_x_max_s, nxt_y_min_s, nxt_y_max_s;

  assign boundary_s = (vsync == VS_POL) && (vsync_d_r != VS_POL);
  assign publish_s  = (state_r == ACC) && boundary_s;
  assign qual_s     = pix_valid && pix_bit &&
                      (int'(pix_x) >= ROI_X0) && (int'(pix_x) <= ROI_X1) &&
                      (int'(pix_y) >= ROI_Y0) && (int'(pix_y) <= ROI_Y1);

  // vsync delay; reset to the active level so a vsync already asserted is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_r <= VS_POL;
    end else begin
      vsync_d_r <= vsync;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: the first boundary only arms publishing, discarding the partial frame.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT: begin
        if (boundary_s) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      ACC:     state_nxt_s = ACC;
      default: state_nxt_s = WAIT;
    endcase
  end

  // Saturating set-pixel counter; a boundary-cycle pixel seeds the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (boundary_s) begin
      cnt_r <= qual_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (qual_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  bbox_axis_acc u_acc_x (
    .clk   (clk),
    .rst   (rst),
    .clear (boundary_s),
    .upd   (qual_s),
    .coord (pix_x),
    .min   (acc_x_min_s),
    .max   (acc_x_max_s)
  );

  bbox_axis_acc u_acc_y (
    .clk   (clk),
    .rst   (rst),
    .clear (boundary_s),
    .upd   (qual_s),
    .coord (pix_y),
    .min   (acc_y_min_s),
    .max   (acc_y_max_s)
  );

  // Box value to load on a valid publish: direct, or averaged with a previously valid box.
  always_comb begin
    nxt_x_min_s = acc_x_min_s;
    nxt_x_max_s = acc_x_max_s;
    nxt_y_min_s = acc_y_min_s;
    nxt_y_max_s = acc_y_max_s;
`ifdef BBOX_SMOOTH_EN
    if (bbox_valid) begin
      nxt_x_min_s = coord_avg(x_min, acc_x_min_s);
      nxt_x_max_s = coord_avg(x_max, acc_x_max_s);
      nxt_y_min_s = coord_avg(y_min, acc_y_min_s);
      nxt_y_max_s = coord_avg(y_max, acc_y_max_s);
    end else begin
      nxt_x_min_s = acc_x_min_s;
      nxt_x_max_s = acc_x_max_s;
      nxt_y_min_s = acc_y_min_s;
      nxt_y_max_s = acc_y_max_s;
    end
`endif
  end

  // Published outputs; under-populated frames keep the previous box but clear bbox_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_min      <= COORD_ZERO;
      x_max      <= COORD_ZERO;
      y_min      <= COORD_ZERO;
      y_max      <= COORD_ZERO;
      bbox_valid <= 1'b0;
      pix_count  <= {CNT_W{1'b0}};
      frame_done <= 1'b0;
    end else if (publish_s) begin
      frame_done <= 1'b1;
      pix_count  <= cnt_r;
      if (cnt_r >= CNT_MIN) begin
        x_min      <= nxt_x_min_s;
        x_max      <= nxt_x_max_s;
        y_min      <= nxt_y_min_s;
        y_max      <= nxt_y_max_s;
        bbox_valid <= 1'b1;
      end else begin
        bbox_valid <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule
